bloom_ctrl: RTL

// - Sequencer that executes bloom-filter custom instructions (INSERT, CHECK, CLEAR) issued by the EX stage.
// - Owns hashing and read-modify-write sequencing of an external single-port filter bit-array RAM.
// - Sits between the custom-instruction decode in EX and the filter storage.
// - Returns a match bit to EX through a one-cycle response strobe.

---
 rtl/bloom_pkg.sv | 7 +
 rtl/bloom_hash.sv | 18 +
 rtl/bloom_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/bloom_pkg.sv
// bloom_pkg: shared types and hash seeds for the bloom-filter controller
package bloom_pkg;
  localparam int WORD_W = 32;
  typedef enum logic [1:0] {OP_ILL, OP_INSERT, OP_CHECK, OP_CLEAR} bloom_op_e;
  typedef enum logic [2:0] {IDLE, RD, WAIT, WR, CLR, RESP} bloom_state_e;
  localparam logic [31:0] SEED [4] = '{32'h9E3779B1, 32'h85EBCA77, 32'hC2B2AE3D, 32'h27D4EB2F};
endpackage

// File: rtl/bloom_hash.sv
// bloom_hash: multiplicative hash of an element into a filter word address and bit index
//   data_i  element value
//   k_i     hash function number (selects the seed)
//   word_o  RAM word holding the filter bit
//   bit_o   bit position inside that word
module bloom_hash
  import bloom_pkg::*;
#(
  parameter int IDX_W = 10
) (
  input  logic [31:0]      data_i,
  input  logic [1:0]       k_i,
  output logic [IDX_W-6:0] word_o,
  output logic [4:0]       bit_o
);
  // top IDX_W bits of the low 32 bits of the product
  assign {word_o, bit_o} = IDX_W'((data_i * SEED[k_i]) >> (32 - IDX_W));
endmodule

// File: rtl/bloom_ctrl.sv
// bloom_ctrl: sequences INSERT/CHECK/CLEAR bloom-filter instructions against an external bit-array RAM
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_valid_i/req_ready_o       operation handshake from EX (ready only in IDLE)
//   req_op_i, req_data_i          opcode and element, sampled at accept
//   rsp_valid_o, rsp_match_o      one-cycle completion pulse and CHECK result (held until next response)
//   busy_o, ins_cnt_o             activity flag and saturating INSERT count since last CLEAR
//   mem_req_o .. mem_rdata_i      single-port RAM interface, read data valid the cycle after a read
module bloom_ctrl
  import bloom_pkg::*;
#(
  parameter  int FILTER_BITS = 1024,
  parameter  int NUM_HASH    = 3,
  localparam int IDX_W       = $clog2(FILTER_BITS),
  localparam int DEPTH       = FILTER_BITS / WORD_W,
  localparam int ADDR_W      = IDX_W - 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_op_i,
  input  logic [31:0]       req_data_i,
  output logic              rsp_valid_o,
  output logic              rsp_match_o,
  output logic              busy_o,
  output logic [15:0]       ins_cnt_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);
  bloom_state_e      state_q, state_d;
  bloom_op_e         op_q;
  logic [31:0]       data_q, wr_q;
  logic [1:0]        k_q;
  logic [ADDR_W-1:0] clr_q, word;
  logic [4:0]        bit_idx;
  logic [15:0]       ins_q;
  logic              match_q, hit, last;

  bloom_hash #(.IDX_W(IDX_W)) u_hash (
    .data_i(data_q),
    .k_i   (k_q),
    .word_o(word),
    .bit_o (bit_idx)
  );

  assign hit         = mem_rdata_i[bit_idx];
  assign last        = k_q == 2'(NUM_HASH - 1);
  assign req_ready_o = state_q == IDLE;
  assign busy_o      = !req_ready_o;
  assign rsp_valid_o = state_q == RESP;
  assign rsp_match_o = match_q;
  assign ins_cnt_o   = ins_q;
  assign mem_req_o   = state_q inside {RD, WR, CLR};
  assign mem_we_o    = state_q inside {WR, CLR};
  assign mem_addr_o  = state_q == CLR ? clr_q : mem_req_o ? word : '0;
  assign mem_wdata_o = state_q == WR ? wr_q : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = !req_valid_i ? IDLE : req_op_i == OP_CLEAR ? CLR : req_op_i == OP_ILL ? RESP : RD;
      RD:      state_d = WAIT;
      WAIT:    state_d = op_q == OP_INSERT ? WR : (!hit || last) ? RESP : RD;
      WR:      state_d = last ? RESP : RD;
      CLR:     state_d = clr_q == ADDR_W'(DEPTH - 1) ? RESP : CLR;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      op_q    <= OP_ILL;
      data_q  <= '0;
      wr_q    <= '0;
      k_q     <= '0;
      clr_q   <= '0;
      ins_q   <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid_i) begin
        op_q   <= bloom_op_e'(req_op_i);
        data_q <= req_data_i;
        k_q    <= '0;
        clr_q  <= '0;
      end
      if ((state_q == WAIT && op_q == OP_CHECK && hit && !last) || (state_q == WR && !last))
        k_q <= k_q + 2'd1;
      if (state_q == WAIT)
        wr_q <= mem_rdata_i | (32'd1 << bit_idx);
      if (state_q == CLR)
        clr_q <= clr_q + 1'b1;
      // only a CHECK ending in WAIT with its bit set reaches RESP from WAIT with a hit
      if (state_d == RESP)
        match_q <= state_q == WAIT && hit;
      // IDLE->RESP is the illegal op, whose op_q is stale and must not touch the count
      if (state_d == RESP && state_q != IDLE)
        ins_q <= op_q == OP_CLEAR ? '0 : (op_q == OP_INSERT && ins_q != '1) ? ins_q + 16'd1 : ins_q;
    end
  end
endmodule
